mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 34 +++
 rtl/mem_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_arbiter.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and a single-port memory.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if;
    logic        req0;
    logic        req1;
    logic        we0;
    logic        we1;
    logic [31:0] addr0;
    logic [31:0] addr1;
    logic [31:0] wdata0;
    logic [31:0] wdata1;
    logic        done0;
    logic        done1;
    logic        stall0;
    logic        stall1;
    logic [31:0] rdata;
    logic        mem_renable;
    logic        mem_wenable;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output done0, done1, stall0, stall1, rdata,
               mem_renable, mem_wenable, mem_addr, mem_wdata
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  done0, done1, stall0, stall1, rdata,
               mem_renable, mem_wenable, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter with round-robin tie breaking.
// One access at a time: IDLE grants, BUSY holds the memory strobe for
// LATENCY cycles, DONE pulses the completion to the granted requester.
module mem_arbiter #(
    parameter int LATENCY = 4
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic        gnt;
    logic        gnt_we;
    logic [31:0] gnt_addr;
    logic [31:0] gnt_wdata;
    logic        prio;
    logic [31:0] rdata_q;

    logic        grant_fire;
    logic        grant_sel;
    logic        done0;
    logic        done1;
    logic        renable;
    logic        wenable;

    // Arbitration choice: a tie goes to whoever the pointer favours.
    always_comb begin
        grant_sel = 1'b0;
        if (bus.req0 && bus.req1) begin
            grant_sel = prio;
        end else begin
            grant_sel = bus.req1;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_nxt  = state;
        grant_fire = 1'b0;
        done0      = 1'b0;
        done1      = 1'b0;
        renable    = 1'b0;
        wenable    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    grant_fire = 1'b1;
                    state_nxt  = BUSY;
                end
            end
            BUSY: begin
                renable = ~gnt_we;
                wenable = gnt_we;
                if (cnt == 4'd0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done0     = ~gnt;
                done1     = gnt;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register; reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant capture, latency counter, pointer update and read-data capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= 4'd0;
            gnt       <= 1'b0;
            gnt_we    <= 1'b0;
            gnt_addr  <= 32'd0;
            gnt_wdata <= 32'd0;
            prio      <= 1'b0;
            rdata_q   <= 32'd0;
        end else if (grant_fire) begin
            gnt       <= grant_sel;
            gnt_we    <= grant_sel ? bus.we1    : bus.we0;
            gnt_addr  <= grant_sel ? bus.addr1  : bus.addr0;
            gnt_wdata <= grant_sel ? bus.wdata1 : bus.wdata0;
            cnt       <= CNT_LOAD;
        end else if (state == BUSY) begin
            if (cnt == 4'd0) begin
                // Entering DONE: the other requester wins the next tie.
                prio <= ~gnt;
                if (!gnt_we) begin
                    rdata_q <= bus.mem_rdata;
                end
            end else begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    assign bus.done0       = done0;
    assign bus.done1       = done1;
    assign bus.stall0      = bus.req0 & ~done0;
    assign bus.stall1      = bus.req1 & ~done1;
    assign bus.rdata       = rdata_q;
    assign bus.mem_renable = renable;
    assign bus.mem_wenable = wenable;
    assign bus.mem_addr    = gnt_addr;
    assign bus.mem_wdata   = gnt_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: randomized two-requester traffic scored against
// a transaction-level model, plus directed LATENCY=1 and reset-mid-access runs.
module tb_mem_arbiter;

    localparam int LAT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter_if bus ();
    mem_arbiter_if bus1 ();

    mem_arbiter #(.LATENCY(LAT)) u_dut (.clk(clk), .rst(rst), .bus(bus.slave));
    mem_arbiter #(.LATENCY(1))   u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5AA5A5;
    endfunction

    // Requester drive for the main instance
    logic [1:0]  r_req;
    logic [1:0]  r_we;
    logic [31:0] r_addr [2];
    logic [31:0] r_wdata [2];

    assign bus.req0      = r_req[0];
    assign bus.req1      = r_req[1];
    assign bus.we0       = r_we[0];
    assign bus.we1       = r_we[1];
    assign bus.addr0     = r_addr[0];
    assign bus.addr1     = r_addr[1];
    assign bus.wdata0    = r_wdata[0];
    assign bus.wdata1    = r_wdata[1];
    assign bus.mem_rdata = mem_fn(bus.mem_addr);
    assign bus1.mem_rdata = 32'hDEADBEEF;

    typedef struct {
        int          who;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          g;
        int          dc;
    } exp_t;

    exp_t        sbq[$];
    logic [1:0]  pend;
    logic [1:0]  gnt_f;
    int          done_at [2];
    int          free_at;
    int          prio_m;
    logic [31:0] rdata_m;
    bit          sb_on = 1'b0;
    bit          allow_new = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction-level model: requesters issue/hold/drop, the arbiter is a
    // resource free again one cycle after each completion.
    task automatic model_step();
        int   c;
        int   w;
        bit   c0;
        bit   c1;
        exp_t e;
        c = cyc;
        for (int n = 0; n < 2; n++) begin
            if (gnt_f[n] && c == done_at[n]) begin
                gnt_f[n] = 1'b0;
                pend[n]  = 1'b0;
                r_req[n] = 1'b0;
            end
        end
        for (int n = 0; n < 2; n++) begin
            if (allow_new && !pend[n] && $urandom_range(0, 2) != 0) begin
                pend[n]    = 1'b1;
                r_req[n]   = 1'b1;
                r_we[n]    = 1'($urandom_range(0, 1));
                r_addr[n]  = $urandom;
                r_wdata[n] = $urandom;
            end
        end
        for (int n = 0; n < 2; n++) begin
            if (gnt_f[n] && r_req[n] && c < done_at[n] && $urandom_range(0, 15) == 0) begin
                r_req[n] = 1'b0;
            end
        end
        if (c >= free_at && gnt_f == 2'b00) begin
            c0 = pend[0] && r_req[0];
            c1 = pend[1] && r_req[1];
            if (c0 || c1) begin
                w = (c0 && c1) ? prio_m : (c1 ? 1 : 0);
                e.who   = w;
                e.we    = r_we[w];
                e.addr  = r_addr[w];
                e.wdata = r_wdata[w];
                if (!e.we) rdata_m = mem_fn(e.addr);
                e.rdata = rdata_m;
                e.g     = c + 1;
                e.dc    = c + 1 + LAT;
                sbq.push_back(e);
                gnt_f[w]   = 1'b1;
                done_at[w] = e.dc;
                free_at    = e.dc + 1;
                prio_m     = (w == 0) ? 1 : 0;
            end
        end
    endtask

    // Monitor: per-cycle strobe/stall checks, scoreboard pop on each done pulse.
    exp_t m_e;
    bit   m_have;
    bit   m_busy;
    bit   m_ed0;
    bit   m_ed1;
    int   m_c;
    always begin
        @(posedge clk);
        #1;
        if (sb_on && !rst) begin
            m_c    = cyc;
            m_have = sbq.size() > 0;
            if (m_have) m_e = sbq[0];
            m_ed0  = m_have && m_c == m_e.dc && m_e.who == 0;
            m_ed1  = m_have && m_c == m_e.dc && m_e.who == 1;
            m_busy = m_have && m_c >= m_e.g && m_c < m_e.g + LAT;
            chk("mem_renable", 32'(bus.mem_renable), 32'(m_busy && !m_e.we));
            chk("mem_wenable", 32'(bus.mem_wenable), 32'(m_busy && m_e.we));
            if (m_busy) begin
                chk("mem_addr", bus.mem_addr, m_e.addr);
                chk("mem_wdata", bus.mem_wdata, m_e.wdata);
            end
            chk("stall0", 32'(bus.stall0), 32'(r_req[0] && !m_ed0));
            chk("stall1", 32'(bus.stall1), 32'(r_req[1] && !m_ed1));
            if (bus.done0 || bus.done1) begin
                if (!m_have) begin
                    chk("unexpected_done", {30'd0, bus.done1, bus.done0}, 32'd0);
                end else begin
                    chk("done_onehot", 32'(bus.done0 && bus.done1), 32'd0);
                    chk("done_who", 32'(bus.done1), 32'(m_e.who));
                    chk("done_cycle", 32'(m_c), 32'(m_e.dc));
                    chk("rdata", bus.rdata, m_e.rdata);
                    void'(sbq.pop_front());
                end
            end else if (m_have && m_c >= m_e.dc) begin
                chk("done_missing", 32'd0, 32'd1);
                void'(sbq.pop_front());
            end
        end
    end

    initial begin
        int  k;
        bit  found;
        logic d1;
        logic [31:0] rd;

        r_req = 2'b00;
        r_we  = 2'b00;
        for (int n = 0; n < 2; n++) begin
            r_addr[n]  = 32'd0;
            r_wdata[n] = 32'd0;
            done_at[n] = 0;
        end
        pend    = 2'b00;
        gnt_f   = 2'b00;
        free_at = 0;
        prio_m  = 0;
        rdata_m = 32'd0;
        bus1.req0 = 1'b0;  bus1.req1 = 1'b0;
        bus1.we0  = 1'b0;  bus1.we1  = 1'b0;
        bus1.addr0 = 32'd0;  bus1.addr1 = 32'd0;
        bus1.wdata0 = 32'd0; bus1.wdata1 = 32'd0;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_done0", 32'(bus.done0), 32'd0);
        chk("rst_done1", 32'(bus.done1), 32'd0);
        chk("rst_renable", 32'(bus.mem_renable), 32'd0);
        chk("rst_wenable", 32'(bus.mem_wenable), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst_rdata", bus.rdata, 32'd0);
        chk("rst_stall0", 32'(bus.stall0), 32'd0);
        chk("rst_stall1", 32'(bus.stall1), 32'd0);
        chk("rst1_renable", 32'(bus1.mem_renable), 32'd0);

        // LATENCY=1 read on the second instance
        @(negedge clk);
        rst = 1'b0;
        bus1.req0  = 1'b1;
        bus1.we0   = 1'b0;
        bus1.addr0 = 32'h80;
        @(posedge clk); #1;
        chk("l1_busy_renable", 32'(bus1.mem_renable), 32'd1);
        chk("l1_busy_addr", bus1.mem_addr, 32'h80);
        chk("l1_busy_done0", 32'(bus1.done0), 32'd0);
        chk("l1_busy_stall0", 32'(bus1.stall0), 32'd1);
        @(posedge clk); #1;
        chk("l1_done0", 32'(bus1.done0), 32'd1);
        chk("l1_done_stall0", 32'(bus1.stall0), 32'd0);
        chk("l1_done_renable", 32'(bus1.mem_renable), 32'd0);
        chk("l1_rdata", bus1.rdata, 32'hDEADBEEF);
        @(negedge clk);
        bus1.req0 = 1'b0;
        @(posedge clk); #1;
        chk("l1_after_done0", 32'(bus1.done0), 32'd0);

        // Randomized traffic on the main instance
        @(negedge clk);
        sb_on     = 1'b1;
        allow_new = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            model_step();
            @(negedge clk);
        end
        allow_new = 1'b0;
        for (int i = 0; i < 100 && (sbq.size() > 0 || pend != 2'b00); i++) begin
            model_step();
            @(negedge clk);
        end
        @(posedge clk); #1;
        chk("drain_empty", 32'(sbq.size()), 32'd0);
        sb_on = 1'b0;

        // Reset in the third BUSY cycle of a read from requester 1
        @(negedge clk);
        r_req[1]   = 1'b1;
        r_we[1]    = 1'b0;
        r_addr[1]  = 32'h40;
        r_wdata[1] = 32'h0;
        @(posedge clk); #1;
        chk("ra_busy1_renable", 32'(bus.mem_renable), 32'd1);
        chk("ra_busy1_addr", bus.mem_addr, 32'h40);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("ra_busy3_renable", 32'(bus.mem_renable), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("ra_done0", 32'(bus.done0), 32'd0);
        chk("ra_done1", 32'(bus.done1), 32'd0);
        chk("ra_renable", 32'(bus.mem_renable), 32'd0);
        chk("ra_wenable", 32'(bus.mem_wenable), 32'd0);
        chk("ra_mem_addr", bus.mem_addr, 32'd0);
        chk("ra_mem_wdata", bus.mem_wdata, 32'd0);
        chk("ra_rdata", bus.rdata, 32'd0);

        // Tie right after reset: requester 0 must win
        @(negedge clk);
        rst = 1'b0;
        r_req     = 2'b11;
        r_we      = 2'b00;
        r_addr[0] = 32'h100;
        r_addr[1] = 32'h200;
        found = 1'b0;
        k  = 0;
        d1 = 1'b0;
        rd = 32'd0;
        for (int i = 1; i <= 20 && !found; i++) begin
            @(posedge clk); #1;
            if (bus.done0 || bus.done1) begin
                found = 1'b1;
                k  = i;
                d1 = bus.done1;
                rd = bus.rdata;
            end
        end
        chk("tie_done_seen", 32'(found), 32'd1);
        chk("tie_winner", 32'(d1), 32'd0);
        chk("tie_latency", 32'(k), 32'(LAT + 1));
        chk("tie_rdata", rd, mem_fn(32'h100));
        @(negedge clk);
        r_req = 2'b00;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
